lfsr_stream_ctrl: RTL and testbench
===================================

Name: lfsr_stream_ctrl

Overview:
- Sequencer for one LFSR datapath instance (tap/seed configurable, serial 1-bit output, synchronous seed load, per-cycle enable).
- Accepts a command (tap, seed, word count) over valid/ready, loads the LFSR, clocks it, and packs its serial output into WORD_BITS-wide words on a valid/ready stream.
- Stalls the LFSR under output backpressure so no bit is lost or duplicated.

Parameters:
- NBITS, 8, LFSR width; width of tap and seed.
- WORD_BITS, 8, output word width; must be >= 2.
- CNT_W, 16, width of the word-count field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_tap  in  NBITS  tap mask for the run
- cmd_seed  in  NBITS  seed for the run
- cmd_count  in  CNT_W  number of words to produce
- abort  in  1  terminate current run
- lfsr_load  out  1  drives LFSR rst (synchronous seed load)
- lfsr_en  out  1  drives LFSR en
- lfsr_tap  out  NBITS  registered tap to LFSR
- lfsr_seed  out  NBITS  registered seed to LFSR
- lfsr_out  in  1  LFSR serial output (current q[0])
- word_valid  out  1  output word valid
- word_ready  in  1  consumer ready
- word_data  out  WORD_BITS  packed word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset: state IDLE; cmd_ready=1; lfsr_load=0; lfsr_en=0; lfsr_tap=0; lfsr_seed=0; word_valid=0; word_data=0; busy=0; done=0; all counters 0.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: capture tap/seed/count. count==0 -> done pulse next cycle, stay IDLE. Else -> LOAD.
- LOAD: one cycle; lfsr_load=1, lfsr_en=0 -> RUN.
- RUN: lfsr_en=1 when the collect register can accept a bit.
  - Each cycle with lfsr_en=1, lfsr_out is sampled into collect bit [bit_cnt], LSB-first.
  - The first sampled bit is seed[0]. The LFSR shifts toward bit 0, so with WORD_BITS==NBITS the first word equals the seed.
- Word completion: when bit_cnt reaches WORD_BITS-1, the word moves to the output register if it is empty or being emptied this cycle (word_valid&word_ready).
  - Otherwise lfsr_en=0 and the collect register holds, with no LFSR advance, until the output register frees.
- Output register: word_valid stays high and word_data stays stable until word_ready. Back-to-back words are allowed; sustained throughput is 1 word per WORD_BITS cycles.
- After the count-th word is collected: lfsr_en=0 -> DRAIN.
- DRAIN: wait for the final handshake, then done=1 for one cycle -> IDLE.
- cmd_ready=0 in all states except IDLE.
- abort: in LOAD/RUN/DRAIN -> IDLE next cycle.
  - word_valid cleared, partial word discarded, no done pulse.
  - In IDLE, abort is ignored. abort outranks a simultaneous handshake.
- rst mid-run: immediate return to reset values; no done.
- Word counter: CNT_W bits, no wrap; max run is 2^CNT_W-1 words.

Optional Feature:
- Macro: LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
- With the macro: extra output err (1 bit, reset 0).
  - A command with cmd_seed==0 is accepted but not run: err=1 and done=1 for one cycle, no LOAD, stay IDLE.
  - The next accepted command clears err.
- Without the macro: no err port; a zero seed runs normally and yields all-zero words.

Decomposition:
- Shared package lfsr_pkg: state enum (IDLE, LOAD, RUN, DRAIN), state width constant, default NBITS/WORD_BITS/CNT_W constants.
- One natural sub-module: lfsr_word_packer (bit_cnt, collect register, output register, valid/ready, stall signal). The FSM and word counter stay in the top level.

Test Plan:
- Bench pairs the controller with the real LFSR.
- NBITS=8, WORD_BITS=8, seed=8'hA5, tap=8'hB8, count=1, word_ready=1 -> one word 8'hA5 after 1+8 cycles, then done pulse, then cmd_ready=1.
- Same config, count=4 -> 4 words matching a reference LFSR model, spaced 8 cycles, done after the 4th handshake.
- count=3, word_ready held 0 for 20 cycles after the first word_valid -> lfsr_en drops after the second word is collected, word_data stable, no lost or duplicated bits versus the model after release.
- count=0 -> done pulse one cycle after accept, lfsr_load never asserted.
- abort during RUN mid-word (cycle 5 of word 2) -> IDLE next cycle, word_valid=0, no done. A new command then produces its seed as the first word.
- With LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN, seed=0 -> err=1 and done=1, no lfsr_load; next valid command clears err.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding and default sizes for the LFSR stream controller.
package lfsr_pkg;
  localparam int STATE_W = 2;
  localparam int DEF_NBITS = 8;
  localparam int DEF_WORD_BITS = 8;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [STATE_W-1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
endpackage

// File: rtl/lfsr_stream_ctrl_word_packer.sv
// lfsr_word_packer: packs serial bits LSB-first into words and holds them on a valid/ready output.
// The LFSR is only enabled when the incoming bit can be stored, so no bit is lost or repeated.
module lfsr_word_packer #(
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run,
  input  logic                 i_clr,
  input  logic                 i_bit,
  input  logic                 i_ready,
  output logic                 o_en,
  output logic                 o_word_done,
  output logic                 o_valid,
  output logic [WORD_BITS-1:0] o_data
);
  localparam int BW = $clog2(WORD_BITS);
  logic [BW-1:0] r_cnt;
  logic [WORD_BITS-1:0] r_col;
  logic [WORD_BITS-1:0] r_data;
  logic r_valid;
  logic w_last;
  logic w_free;
  assign w_last = r_cnt == BW'(WORD_BITS - 1);
  assign w_free = !r_valid || i_ready;
  // last bit of a word waits until the output register frees
  assign o_en = i_run && !(w_last && !w_free);
  assign o_word_done = o_en && w_last;
  assign o_valid = r_valid;
  assign o_data = r_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_col <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_col <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (o_en) begin
        r_col <= {i_bit, r_col[WORD_BITS-1:1]};
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (o_word_done) begin
        r_data <= {i_bit, r_col[WORD_BITS-1:1]};
        r_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/lfsr_stream_ctrl.sv
// lfsr_stream_ctrl: command-driven sequencer that loads an LFSR and streams its output as words.
// Define LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN to reject zero seeds with an err flag.
module lfsr_stream_ctrl
  import lfsr_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [NBITS-1:0]     cmd_tap,
  input  logic [NBITS-1:0]     cmd_seed,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic                 abort,
  output logic                 lfsr_load,
  output logic                 lfsr_en,
  output logic [NBITS-1:0]     lfsr_tap,
  output logic [NBITS-1:0]     lfsr_seed,
  input  logic                 lfsr_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 busy,
  output logic                 done
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
  ,
  output logic                 err
`endif
);
  state_t r_state;
  logic [NBITS-1:0] r_tap;
  logic [NBITS-1:0] r_seed;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_wcnt;
  logic r_done;
  logic w_word_done;
  logic w_zero;
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
  logic r_err;
  assign w_zero = cmd_seed == '0;
  assign err = r_err;
`else
  assign w_zero = 1'b0;
`endif
  assign cmd_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign lfsr_load = r_state == LOAD;
  assign lfsr_tap = r_tap;
  assign lfsr_seed = r_seed;
  assign done = r_done;
  lfsr_word_packer #(.WORD_BITS(WORD_BITS)) u_packer (
    .clk(clk),
    .rst(rst),
    .i_run(r_state == RUN && !abort),
    .i_clr(abort && r_state != IDLE),
    .i_bit(lfsr_out),
    .i_ready(word_ready),
    .o_en(lfsr_en),
    .o_word_done(w_word_done),
    .o_valid(word_valid),
    .o_data(word_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tap <= '0;
      r_seed <= '0;
      r_count <= '0;
      r_wcnt <= '0;
      r_done <= 1'b0;
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
      r_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_tap <= cmd_tap;
          r_seed <= cmd_seed;
          r_count <= cmd_count;
          r_wcnt <= '0;
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
          r_err <= w_zero;
`endif
          if (w_zero || cmd_count == '0) r_done <= 1'b1;
          else r_state <= LOAD;
        end
        LOAD: r_state <= abort ? IDLE : RUN;
        RUN: if (abort) r_state <= IDLE;
        else if (w_word_done) begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == r_count - 1'b1) r_state <= DRAIN;
        end
        DRAIN: if (abort) r_state <= IDLE;
        else if (word_valid && word_ready) begin
          r_done <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// tb_lfsr_stream_ctrl: drives the controller paired with a behavioural LFSR and checks
// the word stream against a reference bit-sequence model.
module tb_lfsr_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [7:0] cmd_tap = '0;
  logic [7:0] cmd_seed = '0;
  logic [15:0] cmd_count = '0;
  logic abort = 1'b0;
  logic lfsr_load, lfsr_en, lfsr_out;
  logic [7:0] lfsr_tap, lfsr_seed;
  logic word_valid;
  logic word_ready = 1'b1;
  logic [7:0] word_data;
  logic busy, done;
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
  logic err;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_load = 0;
  logic [7:0] got_w[$];
  int got_c[$];
  int done_c[$];
  logic [7:0] q;

  always #5 clk = ~clk;

  lfsr_stream_ctrl #(.NBITS(8), .WORD_BITS(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tap(cmd_tap), .cmd_seed(cmd_seed), .cmd_count(cmd_count), .abort(abort),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .lfsr_tap(lfsr_tap), .lfsr_seed(lfsr_seed),
    .lfsr_out(lfsr_out), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .busy(busy), .done(done)
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
    , .err(err)
`endif
  );

  // LFSR datapath: synchronous seed load, shifts toward bit 0 with XOR feedback into the MSB
  always_ff @(posedge clk) begin
    if (lfsr_load) q <= lfsr_seed;
    else if (lfsr_en) q <= {^(q & lfsr_tap), q[7:1]};
  end
  assign lfsr_out = q[0];

  always @(posedge clk) begin
    if (word_valid && word_ready) begin
      got_w.push_back(word_data);
      got_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (lfsr_load) n_load <= n_load + 1;
    cyc <= cyc + 1;
  end

  // word idx of the stream: bits are the successive LSBs of the register, first word first
  function automatic logic [7:0] model_word(input int seed, input int tap, input int idx);
    int s = seed;
    logic [7:0] w = '0;
    for (int i = 0; i < 8 * idx + 8; i++) begin
      if (i >= 8 * idx) w[i-8*idx] = s[0];
      s = (s >> 1) | (($countones(s & tap) % 2) << 7);
    end
    return w;
  endfunction

  task automatic clear_q();
    got_w.delete();
    got_c.delete();
    done_c.delete();
  endtask

  task automatic send_cmd(input logic [7:0] tap, input logic [7:0] seed, input logic [15:0] cnt, output int e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_tap = tap;
    cmd_seed = seed;
    cmd_count = cnt;
    @(posedge clk);
    e = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int k = 0;
    while (done_c.size() == 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_c.size() == 0) begin
      errors++;
      $display("FAIL %s: no done pulse within %0d cycles", name, lim);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, lfsr_load, lfsr_en, word_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, busy, done, lfsr_load, lfsr_en, word_valid});
    end
    checks++;
    if ({lfsr_tap, lfsr_seed, word_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 000000", {lfsr_tap, lfsr_seed, word_data});
    end
`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
  endtask

  task automatic test_single();
    int e;
    clear_q();
    word_ready = 1'b1;
    send_cmd(8'hB8, 8'hA5, 16'd1, e);
    wait_done("single_done", 40);
    checks++;
    if (got_w.size() != 1 || got_w[0] !== 8'hA5 || got_c[0] != e + 10) begin
      errors++;
      $display("FAIL single_word: got n=%0d w=%h at +%0d want n=1 w=a5 at +10",
               got_w.size(), got_w.size() ? got_w[0] : 8'h0, got_c.size() ? got_c[0] - e : -1);
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != e + 11) begin
      errors++;
      $display("FAIL single_done_time: got +%0d want +11", done_c.size() ? done_c[0] - e : -1);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_count4();
    int e;
    clear_q();
    word_ready = 1'b1;
    send_cmd(8'hB8, 8'hA5, 16'd4, e);
    wait_done("count4_done", 80);
    checks++;
    if (got_w.size() != 4) begin
      errors++;
      $display("FAIL count4_n: got %0d want 4", got_w.size());
    end
    for (int k = 0; k < got_w.size() && k < 4; k++) begin
      checks++;
      if (got_w[k] !== model_word(8'hA5, 8'hB8, k) || got_c[k] != e + 10 + 8 * k) begin
        errors++;
        $display("FAIL count4_w%0d: got %h at +%0d want %h at +%0d", k, got_w[k], got_c[k] - e,
                 model_word(8'hA5, 8'hB8, k), 10 + 8 * k);
      end
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != e + 35) begin
      errors++;
      $display("FAIL count4_done_time: got +%0d want +35", done_c.size() ? done_c[0] - e : -1);
    end
  endtask

  task automatic test_backpressure();
    int e, k;
    logic [7:0] d0;
    logic stable;
    clear_q();
    word_ready = 1'b0;
    send_cmd(8'hB8, 8'hA5, 16'd3, e);
    k = 0;
    while (!word_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    d0 = word_data;
    stable = word_valid;
    repeat (20) begin
      @(negedge clk);
      if (word_data !== d0 || !word_valid) stable = 1'b0;
    end
    checks++;
    if (!stable || d0 !== 8'hA5) begin
      errors++;
      $display("FAIL bp_hold: got stable=%b data=%h want 1 a5", stable, d0);
    end
    checks++;
    if (lfsr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got en=%b busy=%b want 0 1", lfsr_en, busy);
    end
    word_ready = 1'b1;
    wait_done("bp_done", 80);
    checks++;
    if (got_w.size() != 3) begin
      errors++;
      $display("FAIL bp_n: got %0d want 3", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 3; i++) begin
      checks++;
      if (got_w[i] !== model_word(8'hA5, 8'hB8, i)) begin
        errors++;
        $display("FAIL bp_w%0d: got %h want %h", i, got_w[i], model_word(8'hA5, 8'hB8, i));
      end
    end
  endtask

  task automatic test_count0();
    int e, l0;
    clear_q();
    l0 = n_load;
    send_cmd(8'hB8, 8'h5A, 16'd0, e);
    repeat (4) @(negedge clk);
    checks++;
    if (done_c.size() != 1 || done_c[0] != e + 1 || n_load != l0 || got_w.size() != 0) begin
      errors++;
      $display("FAIL count0: got dones=%0d at +%0d loads=%0d words=%0d want 1 +1 0 0",
               done_c.size(), done_c.size() ? done_c[0] - e : -1, n_load - l0, got_w.size());
    end
  endtask

  task automatic test_abort();
    int e, k;
    logic [7:0] tap, seed;
    clear_q();
    word_ready = 1'b1;
    send_cmd(8'hB8, 8'hC3, 16'd3, e);
    k = 0;
    while (!word_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b valid=%b ready=%b want 0 0 1", busy, word_valid, cmd_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_c.size() != 0 || got_w.size() != 1) begin
      errors++;
      $display("FAIL abort_nodone: got dones=%0d words=%0d want 0 1", done_c.size(), got_w.size());
    end
    clear_q();
    tap = 8'($urandom);
    seed = 8'($urandom_range(1, 255));
    send_cmd(tap, seed, 16'd1, e);
    wait_done("abort_rerun_done", 40);
    checks++;
    if (got_w.size() != 1 || got_w[0] !== seed || lfsr_tap !== tap) begin
      errors++;
      $display("FAIL abort_rerun: got n=%0d w=%h tap=%h want 1 %h %h",
               got_w.size(), got_w.size() ? got_w[0] : 8'h0, lfsr_tap, seed, tap);
    end
  endtask

  task automatic test_random();
    int e, k, cnt;
    logic [7:0] tap, seed;
    for (int r = 0; r < 5; r++) begin
      clear_q();
      tap = 8'($urandom);
      seed = 8'($urandom_range(1, 255));
      cnt = $urandom_range(1, 5);
      send_cmd(tap, seed, 16'(cnt), e);
      k = 0;
      while (done_c.size() == 0 && k < 400) begin
        word_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        k++;
      end
      word_ready = 1'b1;
      checks++;
      if (done_c.size() != 1 || got_w.size() != cnt) begin
        errors++;
        $display("FAIL rand%0d_n: got dones=%0d words=%0d want 1 %0d", r, done_c.size(), got_w.size(), cnt);
      end
      for (int i = 0; i < got_w.size() && i < cnt; i++) begin
        checks++;
        if (got_w[i] !== model_word(seed, tap, i)) begin
          errors++;
          $display("FAIL rand%0d_w%0d: got %h want %h", r, i, got_w[i], model_word(seed, tap, i));
        end
      end
    end
  endtask

`ifdef LFSR_STREAM_CTRL_ZERO_SEED_CHK_EN
  task automatic test_zero_seed();
    int e, l0;
    clear_q();
    l0 = n_load;
    send_cmd(8'hB8, 8'h00, 16'd3, e);
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || done_c.size() != 1 || done_c[0] != e + 1 || n_load != l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_seed_err: got err=%b dones=%0d loads=%0d busy=%b want 1 1 0 0",
               err, done_c.size(), n_load - l0, busy);
    end
    clear_q();
    send_cmd(8'hB8, 8'h3C, 16'd1, e);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL zero_seed_clear: got err=%b want 0", err);
    end
    wait_done("zero_seed_rerun_done", 40);
  endtask
`else
  task automatic test_zero_seed();
    int e;
    clear_q();
    send_cmd(8'hB8, 8'h00, 16'd2, e);
    wait_done("zero_seed_done", 60);
    checks++;
    if (got_w.size() != 2 || got_w[0] !== 8'h00 || got_w[1] !== 8'h00) begin
      errors++;
      $display("FAIL zero_seed_words: got n=%0d want 2 zero words", got_w.size());
    end
  endtask
`endif

  task automatic test_rst_midrun();
    int e;
    clear_q();
    send_cmd(8'hB8, 8'h81, 16'd2, e);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0 || cmd_ready !== 1'b1 || lfsr_seed !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b valid=%b ready=%b seed=%h want 0 0 1 00",
               busy, word_valid, cmd_ready, lfsr_seed);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_c.size() != 0 || got_w.size() != 0) begin
      errors++;
      $display("FAIL rst_nodone: got dones=%0d words=%0d want 0 0", done_c.size(), got_w.size());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_count4();
    test_backpressure();
    test_count0();
    test_abort();
    test_random();
    test_zero_seed();
    test_rst_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
